// File: rtl/stream_pkg.sv
// Shared defaults and the output word type for the stream packer.
// Holds the lane width, beats per word, keep-mask width and word layout.
package stream_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 4;
  localparam int KEEP_W         = DEF_LANES;

  typedef struct packed {
    logic                               last;
    logic [KEEP_W-1:0]                  keep;
    logic [DEF_DATA_WIDTH*DEF_LANES-1:0] data;
  } word_t;

endpackage

// File: rtl/stream_packer.sv
// Packs LANES narrow beats into one wide word, lane k = beat k, LSB first.
// Ports: clk, rst (async high); s_valid/s_data/s_last/s_ready upstream;
// m_valid/m_data/m_keep/m_last/m_ready downstream; word_count (saturating).
module stream_packer
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic                        m_valid,
  output logic [DATA_WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]            m_keep,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic [15:0]                 word_count
);

  localparam int IW = $clog2(LANES);

  logic [LANES-1:0][DATA_WIDTH-1:0] acc_data;
  logic [IW-1:0]                    acc_idx;
  logic [LANES-1:0]                 acc_keep;

  logic                        pend;
  logic [DATA_WIDTH*LANES-1:0] pend_data;
  logic [LANES-1:0]            pend_keep;
  logic                        pend_last;

  logic [LANES-1:0][DATA_WIDTH-1:0] nxt_data;
  logic [LANES-1:0]                 nxt_keep;
  logic                             beat;
  logic                             done;
  logic                             out_free;

  assign s_ready  = !pend && !rst;
  assign beat     = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;
  assign done     = beat &&
                    (s_last || acc_idx == IW'(LANES - 1));

  // Word as it looks with the current beat merged in; lanes above
  // acc_idx are still zero because the accumulator clears per word.
  always_comb begin
    nxt_data          = acc_data;
    nxt_data[acc_idx] = s_data;
    nxt_keep          = acc_keep | (LANES'(1) << acc_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data  <= '0;
      acc_idx   <= '0;
      acc_keep  <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
      pend_keep <= '0;
      pend_last <= 1'b0;
    end else if (pend) begin
      // s_ready is low here, so no beat can race the hand-off.
      if (out_free) pend <= 1'b0;
    end else if (beat) begin
      if (done) begin
        acc_data <= '0;
        acc_idx  <= '0;
        acc_keep <= '0;
        if (!out_free) begin
          pend      <= 1'b1;
          pend_data <= nxt_data;
          pend_keep <= nxt_keep;
          pend_last <= s_last;
        end
      end else begin
        acc_data <= nxt_data;
        acc_keep <= nxt_keep;
        acc_idx  <= acc_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (out_free) begin
      if (pend) begin
        m_valid <= 1'b1;
        m_data  <= pend_data;
        m_keep  <= pend_keep;
        m_last  <= pend_last;
      end else if (done) begin
        m_valid <= 1'b1;
        m_data  <= nxt_data;
        m_keep  <= nxt_keep;
        m_last  <= s_last;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (m_valid && m_ready &&
                 word_count != 16'hFFFF) begin
      word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Directed and random checks of stream_packer against a beat-level model.
// Ports are all driven from one initial block; outputs sampled after edges.
module tb_stream_packer;
  import stream_pkg::*;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_ready;
  logic [15:0] word_count;

  stream_packer #(.DATA_WIDTH(8), .LANES(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last),
    .m_ready(m_ready), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  word_t       exp_q[$];
  logic [31:0] acc_w;
  int          acc_n;
  int          wc_model;
  bit          hold;
  logic [37:0] hold_v;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc_w = '0;
    acc_n = 0;
    wc_model = 0;
    hold = 1'b0;
  endtask

  task automatic model_beat(input logic [7:0] d,
                            input logic l);
    word_t w;
    acc_w = acc_w | (32'(d) << (8 * acc_n));
    acc_n++;
    if (acc_n == 4 || l) begin
      w.data = acc_w;
      w.keep = 4'((1 << acc_n) - 1);
      w.last = l;
      exp_q.push_back(w);
      acc_w = '0;
      acc_n = 0;
    end
  endtask

  // One clock: sample handshakes before the edge, check after it.
  task automatic step();
    bit    acc;
    bit    xfer;
    word_t e;
    logic [31:0] mask;
    @(negedge clk);
    acc  = s_valid && s_ready;
    xfer = m_valid && m_ready;
    if (acc) model_beat(s_data, s_last);
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_data", m_data, e.data);
        chk("xfer_keep", m_keep, e.keep);
        chk("xfer_last", m_last, e.last);
      end
      if (wc_model < 16'hFFFF) wc_model++;
    end
    hold   = m_valid && !m_ready;
    hold_v = {m_valid, m_last, m_keep, m_data};
    @(posedge clk);
    #1;
    if (hold)
      chk("stable", {m_valid, m_last, m_keep, m_data},
          hold_v);
    if (m_valid) begin
      mask = '0;
      for (int k = 0; k < 4; k++)
        if (m_keep[k]) mask[8*k +: 8] = 8'hFF;
      chk("keep_zero", m_data & ~mask, 0);
    end
    chk("word_count", word_count, wc_model);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_wc", word_count, 0);
    rst = 1'b0;
    #1;
    chk("rel_s_ready", s_ready, 1);
    model_clear();
  endtask

  task automatic send(input logic [7:0] d,
                      input logic l);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    step();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Four beats -> one full word, one cycle later.
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    chk("w1_not_yet", m_valid, 0);
    send(8'h44, 0);
    chk("w1_valid", m_valid, 1);
    chk("w1_data", m_data, 32'h44332211);
    chk("w1_keep", m_keep, 4'hF);
    chk("w1_last", m_last, 0);
    step();

    // Short packet.
    send(8'hAA, 0);
    send(8'hBB, 1);
    chk("w2_data", m_data, 32'h0000BBAA);
    chk("w2_keep", m_keep, 4'h3);
    chk("w2_last", m_last, 1);
    step();

    // Last on first beat.
    send(8'h5C, 1);
    chk("w3_data", m_data, 32'h0000005C);
    chk("w3_keep", m_keep, 4'h1);
    chk("w3_last", m_last, 1);
    step();

    // Last on final lane: no empty word afterwards.
    for (int i = 0; i < 4; i++)
      send(8'(8'hC0 + i), i == 3);
    chk("w4_keep", m_keep, 4'hF);
    chk("w4_last", m_last, 1);
    step();
    chk("no_empty", m_valid, 0);
    step();
    chk("no_empty2", m_valid, 0);

    // Backpressure: 8 beats with m_ready low.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(8'(8'h10 + i), 0);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_held", m_data, 32'h13121110);
    step();
    chk("bp_s_ready2", s_ready, 0);
    m_ready = 1'b1;
    step();
    chk("bp_w2_data", m_data, 32'h17161514);
    step();
    step();
    chk("bp_wc", word_count, 2);
    chk("bp_drained", exp_q.size(), 0);

    // Sixteen beats back-to-back.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("no_bubble", s_ready, 1);
      send(8'(8'h40 + i), 0);
    end
    step();
    chk("bb_wc", word_count, 4);
    chk("bb_drained", exp_q.size(), 0);

    // Reset mid-packet discards the partial word.
    do_reset();
    send(8'hE1, 0);
    send(8'hE2, 0);
    do_reset();
    step();
    chk("mid_rst_idle", m_valid, 0);
    for (int i = 1; i <= 4; i++)
      send(8'(i), 0);
    chk("post_rst_data", m_data, 32'h04030201);
    chk("post_rst_keep", m_keep, 4'hF);
    step();

    // Random traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = 8'($urandom);
      s_last = ($urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b1;
    repeat (4) step();
    chk("rnd_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8, giving the input byte-lane width in bits.
REQ-002 The block SHALL have the parameter LANES, default 4, giving the input beats per output word; LANES SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream beat valid (driven from the FIFO read side).
- s_data  input  DATA_WIDTH  upstream beat data.
- s_last  input  1  the beat closes the current packet.
- s_ready  output  1  the packer accepts a beat this cycle.
- m_valid  output  1  output word valid.
- m_data  output  DATA_WIDTH*LANES  packed word; beat k sits in lane k, LSB first.
- m_keep  output  LANES  per-lane valid mask.
- m_last  output  1  the word holds the final beat of its packet.
- m_ready  input  1  downstream accepts the word.
- word_count  output  16  count of words transferred; saturates.

Function
REQ-010 A beat SHALL be accepted only in a cycle with s_valid=1 and s_ready=1; an output word SHALL be transferred only in a cycle with m_valid=1 and m_ready=1.
REQ-011 The block SHALL hold an accumulator (lane data, lane index acc_idx 0..LANES-1, keep mask) and a separate output register (m_*).
REQ-012 An accepted beat SHALL be written to lane acc_idx, SHALL set keep bit acc_idx, and SHALL increment acc_idx.
REQ-013 A word SHALL be complete when the accepted beat has acc_idx=LANES-1 or s_last=1; acc_idx SHALL then return to 0 and the keep mask SHALL clear.
REQ-014 Output-free SHALL be defined as (m_valid=0) or (m_valid=1 and m_ready=1) in the current cycle.
REQ-015 If a word completes while output-free holds, the word SHALL load into the output register, and m_valid SHALL be 1 in the next cycle; latency is 1 cycle from the completing beat.
REQ-016 If a word completes while output-free does not hold, the block SHALL set the flag pend, and s_ready SHALL be 0 while pend=1.
REQ-017 While pend=1 and output-free holds, the pending word SHALL move to the output register, and pend SHALL clear in the same edge.
REQ-018 s_ready SHALL equal (not pend) and (not rst); it SHALL be combinational from state only and SHALL NOT depend on s_valid.
REQ-019 When m_ready=1 is held, the block SHALL sustain one beat per cycle with no bubbles.
REQ-020 m_data lanes whose keep bit is 0 SHALL be zero.
REQ-021 m_valid, m_data, m_keep and m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-022 A word that completes and leaves in the same cycle SHALL be loaded; the old word is consumed in that cycle, with no loss and no duplication.
REQ-023 s_last on the first beat SHALL produce m_keep=0001 with m_last=1.
REQ-024 s_last on beat LANES-1 SHALL produce full keep with m_last=1, and no empty word SHALL follow.
REQ-025 word_count SHALL increment on each output transfer and SHALL saturate at 16'hFFFF.

Reset
REQ-030 While rst=1, the block SHALL clear acc_idx, the keep mask, the accumulator data, pend, m_valid, m_data, m_keep, m_last and word_count, and SHALL hold s_ready at 0.
REQ-031 Reset asserted mid-packet SHALL discard the partial accumulator and any held output word; no word SHALL emerge after release.
REQ-032 s_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-040 The shared package stream_pkg SHALL hold the DATA_WIDTH and LANES defaults, the keep-mask width constant, and the word type.
REQ-041 The block SHALL be a single module with no sub-module; the accumulator and the output register SHALL be separate always blocks.

Verification
REQ-050 Reset then beats 11,22,33,44 on consecutive cycles with m_ready=1 -> m_data=44332211, m_keep=1111, m_last=0, one cycle after the beat 44.
REQ-051 Beats AA,BB with s_last on BB -> m_data=0000BBAA, m_keep=0011, m_last=1.
REQ-052 m_ready=0 with 8 beats offered -> first word held stable, pend=1 after beat 8, s_ready=0; raise m_ready -> two words delivered in order, word_count=2.
REQ-053 Continuous 16 beats with m_ready=1 -> s_ready is never 0, 4 words delivered back-to-back, word_count=4.
REQ-054 rst pulsed after 2 beats -> m_valid stays 0; the next beats 01..04 yield 04030201 with no stale lanes.
REQ-055 Bench assertions SHALL hold throughout: output stability under backpressure, no beat loss or duplication (scoreboard), keep-zero lanes equal 0.
